// File: rtl/capture_pkg.sv
// Shared definitions for the logic-analyser capture controller.
// Provides the state encoding, the default sample/time widths and the
// masked trigger compare helper.
package capture_pkg;

    localparam int unsigned CAP_DATA_W = 8;
    localparam int unsigned CAP_TIME_W = 32;
    localparam int unsigned STATE_W    = 3;

    localparam logic [STATE_W-1:0] IDLE    = 3'd0;
    localparam logic [STATE_W-1:0] ARMED   = 3'd1;
    localparam logic [STATE_W-1:0] CAPTURE = 3'd2;
    localparam logic [STATE_W-1:0] READOUT = 3'd3;

    // Only bits set in mask take part in the compare; mask=0 always matches.
    function automatic logic trig_match(
        input logic [CAP_DATA_W-1:0] data,
        input logic [CAP_DATA_W-1:0] mask,
        input logic [CAP_DATA_W-1:0] value
    );
        return (data & mask) == (value & mask);
    endfunction

endpackage

// File: rtl/capture_buffer.sv
// Capture storage: DEPTH entries of {data, relative time}.
// Ports: clk; wr_en/wr_addr/wr_data synchronous write port;
//        rd_addr/rd_data asynchronous read port.
// Storage has no reset; only entries below the capture count are ever read.
module capture_buffer
    import capture_pkg::*;
#(
    parameter  int unsigned DEPTH   = 16,
    parameter  int unsigned ENTRY_W = CAP_DATA_W + CAP_TIME_W,
    localparam int unsigned ADDR_W  = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [ENTRY_W-1:0] wr_data,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic [ENTRY_W-1:0] rd_data
);

    logic [ENTRY_W-1:0] mem_q [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Read port.
    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/capture_controller.sv
// Logic-analyser capture sequencer: waits for a masked trigger on the event
// stream, records up to DEPTH events with trigger-relative timestamps, then
// streams them out over valid/ready.
// Ports: clk, rst (async active-low); arm/abort/stop control pulses;
//        trigMask/trigValue trigger setup; evValid/evData/evTime event input;
//        outValid/outData/outTime/outReady readout stream;
//        state/count/triggered status.
module capture_controller
    import capture_pkg::*;
#(
    parameter  int unsigned DEPTH  = 16,
    parameter  int unsigned DATA_W = CAP_DATA_W,
    parameter  int unsigned TIME_W = CAP_TIME_W,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                arm,
    input  logic                abort,
    input  logic                stop,
    input  logic [DATA_W-1:0]   trigMask,
    input  logic [DATA_W-1:0]   trigValue,
    input  logic                evValid,
    input  logic [DATA_W-1:0]   evData,
    input  logic [TIME_W-1:0]   evTime,
    output logic                outValid,
    output logic [DATA_W-1:0]   outData,
    output logic [TIME_W-1:0]   outTime,
    input  logic                outReady,
    output logic [STATE_W-1:0]  state,
    output logic [ADDR_W:0]     count,
    output logic                triggered
);

    localparam int unsigned ENTRY_W = DATA_W + TIME_W;
    localparam int unsigned CNT_W   = ADDR_W + 1;

    logic [STATE_W-1:0] state_q,     state_d;
    logic [CNT_W-1:0]   count_q,     count_d;
    logic               triggered_q, triggered_d;
    logic [ADDR_W-1:0]  rd_ptr_q,    rd_ptr_d;
    logic [TIME_W-1:0]  trig_time_q, trig_time_d;
    logic               out_valid_q, out_valid_d;
    logic [DATA_W-1:0]  out_data_q,  out_data_d;
    logic [TIME_W-1:0]  out_time_q,  out_time_d;

    logic               wr_en;
    logic [ADDR_W-1:0]  wr_addr;
    logic [ENTRY_W-1:0] wr_data;
    logic [ENTRY_W-1:0] rd_data;

    logic ev_trig;
    logic handshake;
    logic last_entry;

    assign ev_trig    = evValid && trig_match(evData, trigMask, trigValue);
    assign handshake  = out_valid_q && outReady;
    assign last_entry = ({1'b0, rd_ptr_q} == (count_q - CNT_W'(1)));

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            triggered_q <= 1'b0;
            rd_ptr_q    <= '0;
            trig_time_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_time_q  <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            triggered_q <= triggered_d;
            rd_ptr_q    <= rd_ptr_d;
            trig_time_q <= trig_time_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_time_q  <= out_time_d;
        end
    end

    // Next state plus capture bookkeeping; abort overrides everything.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        triggered_d = triggered_q;
        rd_ptr_d    = rd_ptr_q;
        trig_time_d = trig_time_q;
        wr_en       = 1'b0;
        wr_addr     = count_q[ADDR_W-1:0];
        wr_data     = {evData, TIME_W'(evTime - trig_time_q)};

        if (abort) begin
            state_d     = IDLE;
            count_d     = '0;
            triggered_d = 1'b0;
            rd_ptr_d    = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (arm) begin
                        state_d     = ARMED;
                        count_d     = '0;
                        triggered_d = 1'b0;
                    end
                end
                ARMED: begin
                    if (stop) begin
                        state_d = IDLE;
                        count_d = '0;
                    end else if (ev_trig) begin
                        state_d     = CAPTURE;
                        wr_en       = 1'b1;
                        wr_addr     = '0;
                        wr_data     = {evData, TIME_W'(0)};
                        trig_time_d = evTime;
                        count_d     = CNT_W'(1);
                        triggered_d = 1'b1;
                    end
                end
                CAPTURE: begin
                    if (stop) begin
                        state_d = READOUT;
                    end else if (evValid) begin
                        wr_en   = 1'b1;
                        count_d = count_q + CNT_W'(1);
                        // Buffer full: stop accepting events and drain.
                        if (count_q == CNT_W'(DEPTH - 1)) begin
                            state_d = READOUT;
                        end
                    end
                end
                READOUT: begin
                    if (handshake) begin
                        if (last_entry) begin
                            state_d  = IDLE;
                            rd_ptr_d = '0;
                        end else begin
                            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Readout registers look ahead to the next state and read pointer so the
    // entry is presented in the same cycle the state shows READOUT.
    always_comb begin
        out_valid_d = (state_d == READOUT);
        out_data_d  = '0;
        out_time_d  = '0;
        if (out_valid_d) begin
            out_data_d = rd_data[ENTRY_W-1:TIME_W];
            out_time_d = rd_data[TIME_W-1:0];
        end
    end

    capture_buffer #(
        .DEPTH   (DEPTH),
        .ENTRY_W (ENTRY_W)
    ) u_buffer (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_ptr_d),
        .rd_data (rd_data)
    );

    assign outValid  = out_valid_q;
    assign outData   = out_data_q;
    assign outTime   = out_time_q;
    assign state     = state_q;
    assign count     = count_q;
    assign triggered = triggered_q;

endmodule

// File: tb/tb_capture_controller.sv
// Self-checking bench for capture_controller: directed scenarios followed by
// randomized capture sessions checked against a queue-based reference model.
module tb_capture_controller;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned TIME_W = 32;
    localparam int unsigned ADDR_W = $clog2(DEPTH);

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              arm = 1'b0;
    logic              abort = 1'b0;
    logic              stop = 1'b0;
    logic [DATA_W-1:0] trigMask = '0;
    logic [DATA_W-1:0] trigValue = '0;
    logic              evValid = 1'b0;
    logic [DATA_W-1:0] evData = '0;
    logic [TIME_W-1:0] evTime = '0;
    logic              outValid;
    logic [DATA_W-1:0] outData;
    logic [TIME_W-1:0] outTime;
    logic              outReady = 1'b0;
    logic [2:0]        state;
    logic [ADDR_W:0]   count;
    logic              triggered;

    always #5 clk = ~clk;

    capture_controller #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .TIME_W (TIME_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .arm       (arm),
        .abort     (abort),
        .stop      (stop),
        .trigMask  (trigMask),
        .trigValue (trigValue),
        .evValid   (evValid),
        .evData    (evData),
        .evTime    (evTime),
        .outValid  (outValid),
        .outData   (outData),
        .outTime   (outTime),
        .outReady  (outReady),
        .state     (state),
        .count     (count),
        .triggered (triggered)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: the entries the host should receive, in order.
    logic [DATA_W-1:0] exp_d[$];
    logic [TIME_W-1:0] exp_t[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ev(input logic [DATA_W-1:0] d, input logic [TIME_W-1:0] t);
        evValid = 1'b1;
        evData  = d;
        evTime  = t;
        cyc();
        evValid = 1'b0;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        cyc();
        arm = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
    endtask

    task automatic push(input logic [DATA_W-1:0] d, input logic [TIME_W-1:0] t);
        exp_d.push_back(d);
        exp_t.push_back(t);
    endtask

    task automatic status(input string tag, input int st, input int cnt, input int trg);
        chk({tag, ".state"}, 64'(state), 64'(st));
        chk({tag, ".count"}, 64'(count), 64'(cnt));
        chk({tag, ".triggered"}, 64'(triggered), 64'(trg));
    endtask

    // Drain the expected queue over valid/ready, stalling stall_len cycles
    // before accepting entry stall_idx and checking stability meanwhile.
    task automatic readout(input string tag, input int stall_idx, input int stall_len);
        int n;
        int w;
        int st;
        n = exp_d.size();
        for (int i = 0; i < n; i++) begin
            w = 0;
            while (outValid !== 1'b1 && w < 20) begin
                cyc();
                w++;
            end
            chk({tag, ".valid"}, 64'(outValid), 64'(1));
            chk({tag, ".data"}, 64'(outData), 64'(exp_d[i]));
            chk({tag, ".time"}, 64'(outTime), 64'(exp_t[i]));
            st = (i == stall_idx) ? stall_len : 0;
            for (int s = 0; s < st; s++) begin
                cyc();
                chk({tag, ".stall_valid"}, 64'(outValid), 64'(1));
                chk({tag, ".stall_data"}, 64'(outData), 64'(exp_d[i]));
                chk({tag, ".stall_time"}, 64'(outTime), 64'(exp_t[i]));
            end
            outReady = 1'b1;
            cyc();
            outReady = 1'b0;
        end
        status({tag, ".done"}, 0, n, 1);
        chk({tag, ".done_valid"}, 64'(outValid), 64'(0));
        chk({tag, ".done_data"}, 64'(outData), 64'(0));
    endtask

    // One randomized arm/capture/stop/readout session against the model.
    task automatic rand_session();
        logic [DATA_W-1:0] m;
        logic [DATA_W-1:0] v;
        logic [DATA_W-1:0] d;
        logic [TIME_W-1:0] t;
        logic [TIME_W-1:0] tt;
        bit                trig;
        int                nev;
        m = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
        v = 8'($urandom);
        trigMask  = m;
        trigValue = v;
        exp_d.delete();
        exp_t.delete();
        trig = 0;
        tt   = '0;
        do_arm();
        status("rnd.armed", 1, 0, 0);
        nev = $urandom_range(1, 8);
        t   = $urandom;
        for (int k = 0; k < nev; k++) begin
            d = 8'($urandom);
            if ($urandom_range(0, 2) == 0) d = (d & ~m) | (v & m);
            t = t + 32'($urandom_range(1, 50));
            if (!trig) begin
                if ((d & m) == (v & m)) begin
                    trig = 1;
                    tt   = t;
                    push(d, '0);
                end
            end else if (exp_d.size() < DEPTH) begin
                push(d, t - tt);
            end
            ev(d, t);
            cyc($urandom_range(0, 2));
        end
        do_stop();
        if (trig) begin
            status("rnd.stopped", 3, exp_d.size(), 1);
            readout("rnd", $urandom_range(0, exp_d.size() - 1), $urandom_range(0, 3));
        end else begin
            status("rnd.notrig", 0, 0, 0);
            chk("rnd.notrig_valid", 64'(outValid), 64'(0));
        end
    endtask

    initial begin
        // Reset values.
        #2;
        status("reset", 0, 0, 0);
        chk("reset.valid", 64'(outValid), 64'(0));
        chk("reset.data", 64'(outData), 64'(0));
        chk("reset.time", 64'(outTime), 64'(0));
        cyc(2);
        rst = 1'b1;
        cyc();
        status("post_reset", 0, 0, 0);

        // Basic capture: 0x10 ignored, trigger on 0x25.
        trigMask  = 8'hF0;
        trigValue = 8'h20;
        do_arm();
        status("basic.arm", 1, 0, 0);
        ev(8'h10, 32'd5);
        status("basic.nomatch", 1, 0, 0);
        ev(8'h25, 32'd9);
        status("basic.trig", 2, 1, 1);
        ev(8'h30, 32'd12);
        ev(8'h31, 32'd20);
        status("basic.three", 2, 3, 1);
        ev(8'h40, 32'd21);
        status("basic.full", 3, 4, 1);
        exp_d = '{8'h25, 8'h30, 8'h31, 8'h40};
        exp_t = '{32'd0, 32'd3, 32'd11, 32'd12};
        readout("basic", -1, 0);

        // Same capture with a 5-cycle stall on the second entry.
        do_arm();
        status("bp.arm", 1, 0, 0);
        ev(8'h10, 32'd5);
        ev(8'h25, 32'd9);
        ev(8'h30, 32'd12);
        ev(8'h31, 32'd20);
        ev(8'h40, 32'd21);
        readout("bp", 1, 5);

        // Abort in CAPTURE with a coincident event.
        do_arm();
        ev(8'h25, 32'd100);
        ev(8'h26, 32'd101);
        status("abort.pre", 2, 2, 1);
        chk("abort.pre_valid", 64'(outValid), 64'(0));
        abort   = 1'b1;
        evValid = 1'b1;
        evData  = 8'h27;
        evTime  = 32'd102;
        cyc();
        abort   = 1'b0;
        evValid = 1'b0;
        status("abort.post", 0, 0, 0);
        chk("abort.post_valid", 64'(outValid), 64'(0));
        cyc(3);
        chk("abort.later_valid", 64'(outValid), 64'(0));

        // Early stop after trigger plus one event.
        do_arm();
        ev(8'h25, 32'd50);
        ev(8'h99, 32'd60);
        do_stop();
        status("stop.readout", 3, 2, 1);
        exp_d = '{8'h25, 8'h99};
        exp_t = '{32'd0, 32'd10};
        readout("stop", -1, 0);
        do_arm();
        status("stop.rearm", 1, 0, 0);
        do_stop();
        status("stop.armed_stop", 0, 0, 0);

        // Timestamp wrap-around.
        do_arm();
        ev(8'h25, 32'hFFFF_FFFE);
        ev(8'h33, 32'h0000_0001);
        do_stop();
        exp_d = '{8'h25, 8'h33};
        exp_t = '{32'd0, 32'd3};
        readout("wrap", -1, 0);

        // Asynchronous reset in the middle of readout.
        do_arm();
        ev(8'h20, 32'd7);
        ev(8'h21, 32'd8);
        do_stop();
        chk("rstmid.pre_valid", 64'(outValid), 64'(1));
        rst = 1'b0;
        #1;
        status("rstmid.now", 0, 0, 0);
        chk("rstmid.valid", 64'(outValid), 64'(0));
        chk("rstmid.data", 64'(outData), 64'(0));
        chk("rstmid.time", 64'(outTime), 64'(0));
        cyc(2);
        rst = 1'b1;
        cyc();
        ev(8'h20, 32'd30);
        ev(8'h21, 32'd31);
        outReady = 1'b1;
        cyc(2);
        outReady = 1'b0;
        status("rstmid.idle", 0, 0, 0);
        chk("rstmid.idle_valid", 64'(outValid), 64'(0));

        // Randomized sessions.
        for (int r = 0; r < 25; r++) begin
            rand_session();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/capture_controller.md
Name: capture_controller

Overview:
- Sequences a logic-analyser capture. It consumes change events (data plus timestamp, one-cycle valid) from signal_analyser and waits for a masked trigger match.
- After the trigger it records up to DEPTH events into an internal buffer, with timestamps made relative to the trigger.
- It then streams the buffer out over a valid/ready interface to the host link.
- It sits between signal_analyser and the readout/UART path.

Parameters:
DEPTH, 16, number of capture entries (power of two, >= 2)
DATA_W, 8, sample width; matches the analyser data width
TIME_W, 32, timestamp width; matches the analyser time width
ADDR_W, $clog2(DEPTH), derived; not overridden

Ports:
clk  in  1  system clock; all logic on the rising edge
rst  in  1  asynchronous active-low reset
arm  in  1  single-cycle pulse: start waiting for a trigger
abort  in  1  single-cycle pulse: cancel and return to IDLE
stop  in  1  single-cycle pulse: end capture early
trigMask  in  DATA_W  bits that take part in the trigger compare
trigValue  in  DATA_W  required values of the masked bits
evValid  in  1  event strobe (analyser newData)
evData  in  DATA_W  event data (analyser dataOut)
evTime  in  TIME_W  event timestamp (analyser dataTime)
outValid  out  1  readout entry valid
outData  out  DATA_W  readout data
outTime  out  TIME_W  readout relative time
outReady  in  1  consumer accepts the entry
state  out  3  current state encoding (see package)
count  out  ADDR_W+1  number of captured entries
triggered  out  1  trigger has fired in this capture

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, count=0, triggered=0, outValid=0, outData=0, outTime=0, read pointer=0, latched trigger time=0. Buffer contents are not reset.
- States: IDLE, ARMED, CAPTURE, READOUT.
- Priority in every state: abort > stop > arm/event.
- abort: next state is IDLE. count, triggered and read pointer clear. An event in the same cycle is discarded.
- IDLE:
  - arm -> ARMED next cycle; count cleared.
  - Events are ignored.
- ARMED:
  - evValid && ((evData & trigMask) == (trigValue & trigMask)) is a trigger.
  - On a trigger: write entry 0 = {evData, 0}, latch trigTime=evTime, count=1, triggered=1, go to CAPTURE.
  - Non-matching events are ignored.
  - trigMask=0 triggers on the first event.
  - arm while ARMED is ignored.
  - stop while ARMED -> IDLE with count=0.
- CAPTURE:
  - evValid writes entry[count] = {evData, evTime - trigTime}. The subtraction is modulo 2^TIME_W, so wrap-around gives the correct elapsed time.
  - count increments; the new value is visible the cycle after the strobe.
  - When a write makes count == DEPTH -> READOUT. No further events are written, so there is no overflow.
  - stop -> READOUT with the current count. An event in the same cycle as stop is discarded.
- READOUT:
  - outValid=1 and {outData, outTime} = entry[rdPtr], held stable while outReady=0.
  - outValid && outReady advances rdPtr.
  - On the handshake of entry count-1: next state IDLE, outValid=0, rdPtr=0, count retained, triggered retained until the next arm.
  - Outside READOUT, outValid=0 and outData/outTime=0.
- arm outside IDLE is ignored.
- Reset mid-operation returns every output to its reset value immediately. No partial readout resumes.

Decomposition:
- Package capture_pkg:
  - State localparams: IDLE=0, ARMED=1, CAPTURE=2, READOUT=3.
  - Default widths DATA_W/TIME_W.
  - Helper function trig_match(data, mask, value).
- Sub-module capture_buffer:
  - DEPTH x (DATA_W+TIME_W) register array.
  - One synchronous write port; one asynchronous read port indexed by rdPtr.
  - No reset on the storage.

Test Plan:
- Basic capture. DEPTH=4, mask=0xF0, value=0x20. Arm, then events (0x10,t5), (0x25,t9), (0x30,t12), (0x31,t20), (0x40,t21).
  - The 0x10 event is ignored.
  - Readout is (0x25,0), (0x30,3), (0x31,11), (0x40,12).
  - count=4, then IDLE after the 4th handshake.
- Backpressure. Same capture, outReady low for 5 cycles at the 2nd entry.
  - outValid stays 1 and outData=0x30/outTime=3 stay stable.
  - No entry is skipped or duplicated.
- Abort. Abort in CAPTURE after 2 events, with an event in the same cycle.
  - Next cycle: state=IDLE, count=0, triggered=0.
  - outValid is never asserted.
- Early stop. Stop after the trigger plus 1 more event.
  - Exactly 2 entries are read out, then IDLE.
  - A later arm -> ARMED with count=0.
- Time wrap. Trigger at evTime=0xFFFFFFFE, next event at 0x00000001.
  - The second entry has outTime=3.
- Reset mid-readout. Assert rst low while outValid=1.
  - Same cycle: outValid=0, state=IDLE, outData=0.
  - After release the block stays in IDLE until arm.
